// File: rtl/dadda_pkg.sv
// rtl/dadda_pkg.sv - shared Dadda tree helpers: height sequence, level count, Baugh-Wooley columns
package dadda_pkg;

  // j-th Dadda height: d1 = 2, d(j+1) = floor(1.5 * dj)
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int k = 1; k < 64; k++) begin
      if (k < j) d = (d * 3) / 2;
    end
    return d;
  endfunction

  // Number of reduction levels needed for a matrix whose tallest column is width bits
  function automatic int dadda_levels(input int width);
    int l;
    l = 0;
    for (int j = 1; j < 32; j++) begin
      if (dadda_height(j) < width) l = j;
    end
    return l;
  endfunction

  // Product width helper
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  // Columns that receive the constant ones in signed mode
  function automatic int bw_lo_col(input int width);
    return width;
  endfunction

  function automatic int bw_hi_col(input int width);
    return 2 * width - 1;
  endfunction

endpackage

// File: rtl/dadda_ppgen.sv
// rtl/dadda_ppgen.sv - partial-product matrix with Baugh-Wooley signed correction
module dadda_ppgen
  import dadda_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        signed_mode,
  output logic [WIDTH-1:0][WIDTH-1:0] pp,
  output logic                        bw_one
);

  // pp[i][j] weighs 2^(i+j); in signed mode the cross terms with exactly one MSB are inverted
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (signed_mode && ((i == WIDTH - 1) != (j == WIDTH - 1)))
          pp[i][j] = ~(a[i] & b[j]);
        else
          pp[i][j] = a[i] & b[j];
      end
    end
    bw_one = signed_mode;
  end

endmodule

// File: rtl/dadda_pipelined_multiplier.sv
// rtl/dadda_pipelined_multiplier.sv - pipelined Dadda multiplier with valid/ready on both sides
module dadda_pipelined_multiplier
  import dadda_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW      = prod_width(WIDTH);
  localparam int H       = WIDTH;
  localparam int L       = dadda_levels(WIDTH);
  localparam int M       = (L + 1) / 2;
  localparam bit HAS_PP  = (STAGES >= 3);
  localparam bit HAS_MID = (STAGES >= 2);
  localparam bit HAS_RED = (STAGES >= 4);
  localparam int KM      = HAS_PP ? 1 : 0;
  localparam int KR      = KM + (HAS_MID ? 1 : 0);
  localparam int KO      = STAGES - 1;

  typedef logic [PW-1:0][H-1:0] mat_t;
  typedef logic [PW-1:0][31:0]  cnt_t;

  // Drop every partial product into its weight column; heights are data independent
  function automatic void place(input logic [WIDTH-1:0][WIDTH-1:0] ppi, input logic one,
                                output mat_t mo, output cnt_t co);
    mo = '0;
    co = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        mo[i+j][co[i+j]] = ppi[i][j];
        co[i+j] = co[i+j] + 1;
      end
    end
    mo[bw_lo_col(WIDTH)][co[bw_lo_col(WIDTH)]] = one;
    co[bw_lo_col(WIDTH)] = co[bw_lo_col(WIDTH)] + 1;
    mo[bw_hi_col(WIDTH)][co[bw_hi_col(WIDTH)]] = one;
    co[bw_hi_col(WIDTH)] = co[bw_hi_col(WIDTH)] + 1;
  endfunction

  // One Dadda level: squeeze every column to at most d bits with full/half adders.
  // Column height counts incoming carries; adders consume original bits first.
  function automatic void reduce_level(input mat_t mi, input cnt_t ci, input int d,
                                       output mat_t mo, output cnt_t co);
    logic [2*WIDTH-1:0] wl, cin, cout;
    int n, nin, nout, i, h, o;
    logic s, cy;
    mo  = '0;
    co  = '0;
    cin = '0;
    nin = 0;
    for (int c = 0; c < PW; c++) begin
      wl = '0;
      n  = 0;
      for (int k = 0; k < H; k++) begin
        if (k < ci[c]) begin wl[n] = mi[c][k]; n++; end
      end
      for (int k = 0; k < 2 * WIDTH; k++) begin
        if (k < nin) begin wl[n] = cin[k]; n++; end
      end
      h    = n;
      i    = 0;
      o    = 0;
      cout = '0;
      nout = 0;
      for (int r = 0; r < 2 * WIDTH; r++) begin
        if (h > d) begin
          if (h - d >= 2) begin
            s  = wl[i] ^ wl[i+1] ^ wl[i+2];
            cy = (wl[i] & wl[i+1]) | (wl[i] & wl[i+2]) | (wl[i+1] & wl[i+2]);
            i  = i + 3;
            h  = h - 2;
          end else begin
            s  = wl[i] ^ wl[i+1];
            cy = wl[i] & wl[i+1];
            i  = i + 2;
            h  = h - 1;
          end
          mo[c][o] = s;
          o = o + 1;
          cout[nout] = cy;
          nout = nout + 1;
        end
      end
      for (int k = 0; k < 2 * WIDTH; k++) begin
        if (k >= i && k < n) begin mo[c][o] = wl[k]; o = o + 1; end
      end
      co[c] = o;
      cin   = cout;
      nin   = nout;
    end
  endfunction

  logic [WIDTH-1:0][WIDTH-1:0] pp;
  logic                        bw_one;
  mat_t                        m_pp, pp_q, mid_d, mid_q;
  logic [PW-1:0]               r0_d, r1_d, r0_q, r1_q, r0_s, r1_s, sum;
  logic [STAGES-1:0]           v, vin;
  logic [STAGES:0]             rdy;

  dadda_ppgen #(.WIDTH(WIDTH)) u_ppgen (
    .a           (A),
    .b           (B),
    .signed_mode (signed_mode),
    .pp          (pp),
    .bw_one      (bw_one)
  );

  // Handshake chain: a stage can load when empty or when its successor moves
  always_comb begin
    logic [STAGES:0] r;
    r = '0;
    r[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) r[k] = !v[k] || r[k+1];
    rdy = r;
    vin = '0;
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) vin[k] = v[k-1];
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[KO];

  // Tree datapath; optional registers split it after ppgen, mid-tree and before the CPA
  always_comb begin
    mat_t m;
    cnt_t c;
    mid_d = '0;
    place(pp, bw_one, m_pp, c);
    m = HAS_PP ? pp_q : m_pp;
    for (int lv = 1; lv <= L; lv++) begin
      if (lv == M + 1) begin
        mid_d = m;
        if (HAS_MID) m = mid_q;
      end
      reduce_level(m, c, dadda_height(L - lv + 1), m, c);
    end
    for (int k = 0; k < PW; k++) begin
      r0_d[k] = m[k][0];
      r1_d[k] = m[k][1];
    end
    r0_s = HAS_RED ? r0_q : r0_d;
    r1_s = HAS_RED ? r1_q : r1_d;
    sum  = r0_s + r1_s;
  end

  // Stage valid bits and the output register; reset wins over any transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      v       <= '0;
      product <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) v[k] <= vin[k];
      end
      if (rdy[KO] && vin[KO]) product <= sum;
    end
  end

  // Intermediate data registers, loaded only when a valid item enters the stage
  always_ff @(posedge clk) begin
    if (HAS_PP && rdy[0] && vin[0]) pp_q <= m_pp;
    if (HAS_MID && rdy[KM] && vin[KM]) mid_q <= mid_d;
    if (HAS_RED && rdy[KR] && vin[KR]) begin
      r0_q <= r0_d;
      r1_q <= r1_d;
    end
  end

endmodule

// File: tb/tb_dadda_pipelined_multiplier.sv
// tb/tb_dadda_pipelined_multiplier.sv - scoreboard bench for dadda_pipelined_multiplier
module tb_dadda_pipelined_multiplier;

  localparam int WIDTH  = 16;
  localparam int STAGES = 3;

  logic               clk = 1'b0;
  logic               reset, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] product;

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_emit  = 0;
  logic [31:0] exp_q[$];

  dadda_pipelined_multiplier #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (a),
    .B           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic signed [31:0] sx, sy;
    logic [31:0]        ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {16'b0, x};
    uy = {16'b0, y};
    if (s) return sx * sy;
    return ux * uy;
  endfunction

  // Scoreboard: push on accept, pop and compare on emit
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) check("output_without_input", exp_q.size(), 1);
        else check("scoreboard", product, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, signed_mode));
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s);
    int n;
    a = x; b = y; signed_mode = s; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("send_stuck", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_lat(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat, n, start;
    bit          done;
    logic [31:0] held;
    logic [15:0] ca[7], cb[7];
    logic        cs[7];
    logic [31:0] ce[7];

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_in_ready", in_ready, 1);

    send(16'h2771, 16'h0F67, 1'b0);
    wait_lat(lat);
    check("ref_latency", lat, STAGES);
    check("ref_product", product, 32'd39812471);
    idle(1);

    send(16'hFFFF, 16'h0002, 1'b0);
    send(16'hFFFF, 16'h0002, 1'b1);
    wait_lat(lat);
    check("mode_unsigned", product, 32'h0001FFFE);
    idle(1);
    check("mode_signed_valid", out_valid, 1);
    check("mode_signed", product, 32'hFFFFFFFE);
    idle(1);

    ca[0] = 16'hFFFF; cb[0] = 16'hFFFF; cs[0] = 1'b0; ce[0] = 32'hFFFE0001;
    ca[1] = 16'h8000; cb[1] = 16'h8000; cs[1] = 1'b1; ce[1] = 32'h40000000;
    ca[2] = 16'h8000; cb[2] = 16'h7FFF; cs[2] = 1'b1; ce[2] = 32'hC0008000;
    ca[3] = 16'h1234; cb[3] = 16'h0000; cs[3] = 1'b0; ce[3] = 32'h00000000;
    ca[4] = 16'h0000; cb[4] = 16'hABCD; cs[4] = 1'b1; ce[4] = 32'h00000000;
    ca[5] = 16'hFFFF; cb[5] = 16'hFFFF; cs[5] = 1'b1; ce[5] = 32'h00000001;
    ca[6] = 16'h7FFF; cb[6] = 16'h7FFF; cs[6] = 1'b1; ce[6] = 32'h3FFF0001;
    for (int i = 0; i < 7; i++) begin
      send(ca[i], cb[i], cs[i]);
      wait_lat(lat);
      check($sformatf("corner%0d", i), product, ce[i]);
    end
    idle(2);

    start = n_emit;
    fork
      begin
        for (int i = 0; i < 10; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        @(negedge clk);
        held = product;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_product_hold", product, held);
          check("bp_valid_hold", out_valid, 1);
        end
        check("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_drain", exp_q.size(), 0);
    check("bp_count", n_emit - start, 10);
    idle(2);

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          idle($urandom_range(0, 2));
          send(16'($urandom), 16'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = 1'($urandom); end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("rand_drain", exp_q.size(), 0);
    idle(2);

    send(16'h1111, 16'h2222, 1'b0);
    send(16'h8001, 16'h0003, 1'b1);
    send(16'h0042, 16'hFFF0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_out_valid", out_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no_stale_output", out_valid, 0);
    end
    send(16'h00FF, 16'h0101, 1'b0);
    wait_lat(lat);
    check("post_rst_latency", lat, STAGES);
    check("post_rst_product", product, 32'h0000FFFF);
    idle(1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
